bingo_master_param: RTL and testbench

- Parametrised successor to the 5x5 two-board Bingo master FSM.
- Runs the complete local-side game:
  - start handshake with the peer board
  - board fill (selection)
  - alternating guess turns
  - duplicate/invalid-number rejection
  - optional turn timeout with auto-pick
  - line counting against a configurable win threshold
  - explicit WIN/LOSE result
- Sits between the keypad/BCD front end, the inter-board link (tx/rx message ports) and the display driver (map/circle/line outputs).

---
 rtl/bingo_master_param.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_bingo_master_param.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bingo_master_param.sv
// bingo_master_param: local-side controller for a two-board SIDE x SIDE Bingo game.
// Runs the start handshake, board fill, alternating guess turns with the
// peer, optional turn timeout with auto-pick, line counting and WIN/LOSE.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   link_rst                 reset request from peer board (same effect as rst)
//   start_game               level; starts from IDLE, acknowledges from FIN
//   key_num, key_enter       keypad number and one-cycle commit strobe
//   tx_ready                 link accepts the current message this cycle
//   rx_en, rx_type, rx_num   peer message strobe, type and number
//   tx_en, tx_type, tx_num   outgoing message request, type and number
//   map                      cell numbers, cell 0 in the LSBs, row-major
//   circle                   marked cells
//   line_cnt                 completed lines (rows + columns + diagonals)
//   game_state               current FSM state encoding
//   win, lose                local board won / peer won
//   err_key                  one-cycle pulse: key entry rejected
module bingo_master_param #(
    parameter int unsigned SIDE         = 5,
    parameter int unsigned NUM_W        = 5,
    parameter int unsigned LINES_TO_WIN = 5,
    parameter int unsigned TURN_TIMEOUT = 0,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         link_rst,
    input  logic                         start_game,
    input  logic [NUM_W-1:0]             key_num,
    input  logic                         key_enter,
    input  logic                         tx_ready,
    input  logic                         rx_en,
    input  logic [2:0]                   rx_type,
    input  logic [NUM_W-1:0]             rx_num,
    output logic                         tx_en,
    output logic [2:0]                   tx_type,
    output logic [NUM_W-1:0]             tx_num,
    output logic [SIDE*SIDE*NUM_W-1:0]   map,
    output logic [SIDE*SIDE-1:0]         circle,
    output logic [CNT_W-1:0]             line_cnt,
    output logic [3:0]                   game_state,
    output logic                         win,
    output logic                         lose,
    output logic                         err_key
);

    localparam int unsigned N      = SIDE * SIDE;
    localparam int unsigned IDX_W  = $clog2(N + 1);
    localparam int unsigned TMO_W  = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam bit          TMO_EN = (TURN_TIMEOUT != 0);

    // Inter-board message encodings shared with the peer board
    localparam logic [2:0] MSG_START   = 3'd1;
    localparam logic [2:0] MSG_TURN    = 3'd2;
    localparam logic [2:0] MSG_SEL_NUM = 3'd3;
    localparam logic [2:0] MSG_WIN     = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE          = 4'd0,
        S_SEND_START    = 4'd1,
        S_SELECT        = 4'd2,
        S_WAIT_PEER_SEL = 4'd3,
        S_MY_GUESS      = 4'd4,
        S_SEND_NUM      = 4'd5,
        S_CHECK_MY      = 4'd6,
        S_SEND_TURN     = 4'd7,
        S_WAIT_PEER     = 4'd8,
        S_CHECK_PEER    = 4'd9,
        S_SEND_WIN      = 4'd10,
        S_FIN           = 4'd11
    } state_t;

    state_t                   state_q, state_d;
    logic [N-1:0][NUM_W-1:0]  map_q;
    logic [N-1:0]             circle_q;
    logic [N-1:0]             used_q;     // numbers already guessed by either side
    logic [N-1:0]             placed_q;   // numbers already placed during board fill
    logic [IDX_W-1:0]         idx_q;
    logic [TMO_W-1:0]         tmo_q;

    logic                     sel_wr_c;
    logic                     guess_acc_c;
    logic [NUM_W-1:0]         guess_num_c;
    logic                     peer_acc_c;
    logic                     err_c;
    logic                     win_set_c;
    logic                     lose_set_c;
    logic                     clear_c;
    logic                     auto_ok_c;
    logic [NUM_W-1:0]         auto_num_c;
    logic [CNT_W-1:0]         lines_c;
    logic                     mark_en_c;
    logic [NUM_W-1:0]         mark_num_c;

    // True when n is in 1..N and not yet present in set
    function automatic logic num_free(input logic [NUM_W-1:0] n, input logic [N-1:0] set);
        logic f;
        f = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (n == NUM_W'(i + 1) && !set[i]) f = 1'b1;
        end
        return f;
    endfunction

    // One-hot set bit for number n (zero for out-of-range n)
    function automatic logic [N-1:0] num_bit(input logic [NUM_W-1:0] n);
        logic [N-1:0] b;
        b = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (n == NUM_W'(i + 1)) b[i] = 1'b1;
        end
        return b;
    endfunction

    // Lowest unused number for timeout auto-pick
    always_comb begin
        auto_ok_c  = 1'b0;
        auto_num_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                auto_ok_c  = 1'b1;
                auto_num_c = NUM_W'(i + 1);
            end
        end
    end

    // Completed-line count from the current circle pattern
    always_comb begin
        logic full_r;
        logic full_c;
        logic full_d;
        logic full_a;
        lines_c = '0;
        full_d  = 1'b1;
        full_a  = 1'b1;
        for (int r = 0; r < int'(SIDE); r++) begin
            full_r = 1'b1;
            full_c = 1'b1;
            for (int k = 0; k < int'(SIDE); k++) begin
                full_r = full_r & circle_q[r * int'(SIDE) + k];
                full_c = full_c & circle_q[k * int'(SIDE) + r];
            end
            lines_c = lines_c + CNT_W'(full_r) + CNT_W'(full_c);
        end
        for (int k = 0; k < int'(SIDE); k++) begin
            full_d = full_d & circle_q[k * int'(SIDE) + k];
            full_a = full_a & circle_q[k * int'(SIDE) + int'(SIDE) - 1 - k];
        end
        lines_c = lines_c + CNT_W'(full_d) + CNT_W'(full_a);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst || link_rst) state_q <= S_IDLE;
        else                 state_q <= state_d;
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        sel_wr_c    = 1'b0;
        guess_acc_c = 1'b0;
        guess_num_c = key_num;
        peer_acc_c  = 1'b0;
        err_c       = 1'b0;
        win_set_c   = 1'b0;
        lose_set_c  = 1'b0;
        clear_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_game) state_d = S_SEND_START;
            end
            S_SEND_START: begin
                if (tx_ready) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (key_enter) begin
                    if (num_free(key_num, placed_q)) begin
                        sel_wr_c = 1'b1;
                        if (idx_q == IDX_W'(N - 1)) state_d = S_WAIT_PEER_SEL;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            S_WAIT_PEER_SEL: begin
                if (rx_en && rx_type == MSG_TURN) state_d = S_MY_GUESS;
            end
            S_MY_GUESS: begin
                // A real key strobe wins over a coincident timeout
                if (key_enter) begin
                    if (num_free(key_num, used_q)) begin
                        guess_acc_c = 1'b1;
                        state_d     = S_SEND_NUM;
                    end else begin
                        err_c = 1'b1;
                    end
                end else if (TMO_EN && tmo_q == TMO_W'(TURN_TIMEOUT - 1) && auto_ok_c) begin
                    guess_acc_c = 1'b1;
                    guess_num_c = auto_num_c;
                    state_d     = S_SEND_NUM;
                end
            end
            S_SEND_NUM: begin
                if (tx_ready) state_d = S_CHECK_MY;
            end
            S_CHECK_MY: begin
                state_d = (lines_c >= CNT_W'(LINES_TO_WIN)) ? S_SEND_WIN : S_SEND_TURN;
            end
            S_SEND_TURN: begin
                if (tx_ready) state_d = S_WAIT_PEER;
            end
            S_WAIT_PEER: begin
                if (rx_en) begin
                    if (rx_type == MSG_SEL_NUM && num_free(rx_num, used_q)) begin
                        peer_acc_c = 1'b1;
                        state_d    = S_CHECK_PEER;
                    end else if (rx_type == MSG_WIN) begin
                        lose_set_c = 1'b1;
                        state_d    = S_FIN;
                    end
                end
            end
            S_CHECK_PEER: begin
                state_d = (lines_c >= CNT_W'(LINES_TO_WIN)) ? S_SEND_WIN : S_MY_GUESS;
            end
            S_SEND_WIN: begin
                if (tx_ready) begin
                    win_set_c = 1'b1;
                    state_d   = S_FIN;
                end
            end
            S_FIN: begin
                if (start_game) begin
                    clear_c = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mark_en_c  = guess_acc_c | peer_acc_c;
    assign mark_num_c = guess_acc_c ? guess_num_c : rx_num;

    // Board, line count, result and turn timer registers
    always_ff @(posedge clk) begin
        if (rst || link_rst) begin
            map_q    <= '0;
            circle_q <= '0;
            used_q   <= '0;
            placed_q <= '0;
            idx_q    <= '0;
            line_cnt <= '0;
            win      <= 1'b0;
            lose     <= 1'b0;
            err_key  <= 1'b0;
            tmo_q    <= '0;
        end else begin
            err_key <= err_c;
            if (clear_c) begin
                map_q    <= '0;
                circle_q <= '0;
                used_q   <= '0;
                placed_q <= '0;
                idx_q    <= '0;
                line_cnt <= '0;
                win      <= 1'b0;
                lose     <= 1'b0;
            end else begin
                line_cnt <= lines_c;
                if (sel_wr_c) begin
                    for (int c = 0; c < int'(N); c++) begin
                        if (idx_q == IDX_W'(c)) map_q[c] <= key_num;
                    end
                    placed_q <= placed_q | num_bit(key_num);
                    idx_q    <= idx_q + IDX_W'(1);
                end
                if (mark_en_c) begin
                    for (int c = 0; c < int'(N); c++) begin
                        if (map_q[c] == mark_num_c) circle_q[c] <= 1'b1;
                    end
                    used_q <= used_q | num_bit(mark_num_c);
                end
                if (win_set_c)  win  <= 1'b1;
                if (lose_set_c) lose <= 1'b1;
            end
            // Timer restarts on every entry into MY_GUESS
            if (state_q == S_MY_GUESS && state_d == S_MY_GUESS) tmo_q <= tmo_q + TMO_W'(1);
            else                                                tmo_q <= '0;
        end
    end

    // Outgoing message registers follow the next state so tx_en spans the SEND_* state
    always_ff @(posedge clk) begin
        if (rst || link_rst) begin
            tx_en   <= 1'b0;
            tx_type <= 3'd0;
            tx_num  <= '0;
        end else begin
            tx_en   <= 1'b0;
            tx_type <= 3'd0;
            tx_num  <= '0;
            case (state_d)
                S_SEND_START: begin
                    tx_en   <= 1'b1;
                    tx_type <= MSG_START;
                end
                S_SEND_NUM: begin
                    tx_en   <= 1'b1;
                    tx_type <= MSG_SEL_NUM;
                    tx_num  <= guess_acc_c ? guess_num_c : tx_num;
                end
                S_SEND_TURN: begin
                    tx_en   <= 1'b1;
                    tx_type <= MSG_TURN;
                end
                S_SEND_WIN: begin
                    tx_en   <= 1'b1;
                    tx_type <= MSG_WIN;
                end
                default: ;
            endcase
        end
    end

    assign map        = map_q;
    assign circle     = circle_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_bingo_master_param.sv
// Bench for bingo_master_param (SIDE=5, LINES_TO_WIN=1, TURN_TIMEOUT=8).
// Expected link messages are queued as stimulus is issued; a negedge
// monitor pops and compares them whenever the DUT hands a message over.
module tb_bingo_master_param;

    localparam int unsigned SIDE  = 5;
    localparam int unsigned NUM_W = 5;
    localparam int unsigned N     = SIDE * SIDE;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] M_START = 3'd1;
    localparam logic [2:0] M_TURN  = 3'd2;
    localparam logic [2:0] M_SEL   = 3'd3;
    localparam logic [2:0] M_WIN   = 3'd4;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_SEND_NUM  = 4'd5;
    localparam logic [3:0] ST_SELECT    = 4'd2;
    localparam logic [3:0] ST_WPS       = 4'd3;
    localparam logic [3:0] ST_MY        = 4'd4;
    localparam logic [3:0] ST_WP        = 4'd8;
    localparam logic [3:0] ST_FIN       = 4'd11;

    logic                   clk = 1'b0;
    logic                   rst, link_rst, start_game, key_enter, tx_ready, rx_en;
    logic [NUM_W-1:0]       key_num, rx_num;
    logic [2:0]             rx_type;
    logic                   tx_en, win, lose, err_key;
    logic [2:0]             tx_type;
    logic [NUM_W-1:0]       tx_num;
    logic [N*NUM_W-1:0]     map;
    logic [N-1:0]           circle;
    logic [CNT_W-1:0]       line_cnt;
    logic [3:0]             game_state;

    typedef struct packed {
        logic [2:0]       t;
        logic [NUM_W-1:0] n;
    } msg_t;

    msg_t exp_q[$];
    msg_t mon_m;
    int   total = 0;
    int   passed = 0;
    int   err_seen = 0;
    int   exp_err = 0;
    int   tx_bad = 0;
    logic [N*NUM_W-1:0] exp_map;
    logic [N-1:0]       exp_circle;

    bingo_master_param #(
        .SIDE(SIDE), .NUM_W(NUM_W), .LINES_TO_WIN(1), .TURN_TIMEOUT(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .link_rst(link_rst), .start_game(start_game),
        .key_num(key_num), .key_enter(key_enter), .tx_ready(tx_ready),
        .rx_en(rx_en), .rx_type(rx_type), .rx_num(rx_num),
        .tx_en(tx_en), .tx_type(tx_type), .tx_num(tx_num),
        .map(map), .circle(circle), .line_cnt(line_cnt), .game_state(game_state),
        .win(win), .lose(lose), .err_key(err_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] t, input logic [NUM_W-1:0] n);
        msg_t m;
        m.t = t;
        m.n = n;
        exp_q.push_back(m);
    endtask

    task automatic key(input int n);
        key_num   = NUM_W'(n);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic rx(input logic [2:0] t, input int n);
        rx_type = t;
        rx_num  = NUM_W'(n);
        rx_en   = 1'b1;
        tick();
        rx_en   = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input string name);
        int n;
        n = 0;
        while (game_state !== s && n < 60) begin
            tick();
            n++;
        end
        check(name, game_state, s);
    endtask

    task automatic fill_board();
        for (int i = 1; i <= int'(N); i++) key(i);
    endtask

    task automatic start_pulse();
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
    endtask

    // Monitor: link messages, err pulses, stray tx_en
    always @(negedge clk) begin
        if (!rst && !link_rst) begin
            if (err_key) err_seen++;
            if (tx_en && !(game_state inside {4'd1, 4'd5, 4'd7, 4'd10})) tx_bad++;
            if (tx_en && tx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_tx: got type %0d num %0d, expected none", tx_type, tx_num);
                end else begin
                    mon_m = exp_q.pop_front();
                    check("tx_type", tx_type, mon_m.t);
                    check("tx_num", tx_num, mon_m.n);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; link_rst = 1'b0; start_game = 1'b0; key_enter = 1'b0;
        key_num = '0; tx_ready = 1'b1; rx_en = 1'b0; rx_type = 3'd0; rx_num = '0;
        for (int i = 0; i < int'(N); i++) exp_map[i*NUM_W +: NUM_W] = NUM_W'(i + 1);
        exp_circle = '0;
        for (int i = 0; i < 5; i++) exp_circle[i] = 1'b1;
        exp_circle[9] = 1'b1; exp_circle[14] = 1'b1; exp_circle[19] = 1'b1; exp_circle[23] = 1'b1;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_state", game_state, ST_IDLE);
        check("rst_tx_en", tx_en, 1'b0);
        check("rst_map", map, '0);
        check("rst_circle", circle, '0);
        check("rst_line_cnt", line_cnt, '0);
        check("rst_win_lose", {win, lose, err_key}, 3'b000);

        // Game 1: fill with a duplicate and a zero, then win on row 0
        push(M_START, 0);
        start_pulse();
        wait_state(ST_SELECT, "g1_select");
        for (int i = 1; i <= 7; i++) key(i);
        key(7);
        key(0);
        exp_err += 2;
        for (int i = 8; i <= int'(N); i++) key(i);
        check("fill_done_state", game_state, ST_WPS);
        tick();
        check("fill_err_cnt", err_seen, exp_err);
        check("fill_map", map, exp_map);

        rx(M_TURN, 0);
        check("turn_rx_state", game_state, ST_MY);
        // Turn 1: timeout auto-picks 1 on the 8th MY_GUESS cycle
        push(M_SEL, 1);
        push(M_TURN, 0);
        repeat (7) tick();
        check("tmo_before", game_state, ST_MY);
        tick();
        check("tmo_fire", game_state, ST_SEND_NUM);
        wait_state(ST_WP, "t1_wait_peer");
        rx(M_SEL, 10);
        wait_state(ST_MY, "p1_back");
        check("line_cnt_p1", line_cnt, 4'd0);

        // Turn 2: duplicate and out-of-range keys rejected without tx
        key(1);
        key(26);
        exp_err += 2;
        check("dup_no_tx", game_state, ST_MY);
        push(M_SEL, 2);
        push(M_TURN, 0);
        key(2);
        wait_state(ST_WP, "t2_wait_peer");
        check("guess_err_cnt", err_seen, exp_err);
        rx(M_SEL, 15);
        wait_state(ST_MY, "p2_back");
        push(M_SEL, 3);
        push(M_TURN, 0);
        key(3);
        wait_state(ST_WP, "t3_wait_peer");
        rx(M_SEL, 20);
        wait_state(ST_MY, "p3_back");
        push(M_SEL, 4);
        push(M_TURN, 0);
        key(4);
        wait_state(ST_WP, "t4_wait_peer");
        rx(M_SEL, 10);
        check("peer_dup_ignored", game_state, ST_WP);
        rx(M_SEL, 24);
        wait_state(ST_MY, "p4_back");
        check("line_cnt_p4", line_cnt, 4'd0);
        push(M_SEL, 5);
        push(M_WIN, 0);
        key(5);
        wait_state(ST_FIN, "g1_fin");
        check("g1_win", {win, lose}, 2'b10);
        check("g1_line_cnt", line_cnt, 4'd1);
        check("g1_circle", circle, exp_circle);
        check("g1_tx_en", tx_en, 1'b0);

        // FIN acknowledge clears the board
        start_pulse();
        check("clr_state", game_state, ST_IDLE);
        check("clr_map", map, '0);
        check("clr_circle", circle, '0);
        check("clr_win", {win, lose}, 2'b00);
        tick();
        check("clr_line_cnt", line_cnt, 4'd0);

        // Game 2: peer wins
        push(M_START, 0);
        start_pulse();
        wait_state(ST_SELECT, "g2_select");
        fill_board();
        check("g2_fill_state", game_state, ST_WPS);
        rx(M_TURN, 0);
        wait_state(ST_MY, "g2_my");
        push(M_SEL, 7);
        push(M_TURN, 0);
        key(7);
        wait_state(ST_WP, "g2_wait_peer");
        rx(M_WIN, 0);
        check("g2_fin", game_state, ST_FIN);
        check("g2_lose", {win, lose}, 2'b01);
        check("g2_tx_en", tx_en, 1'b0);

        // Game 3: link reset while a SEL_NUM is stalled
        start_pulse();
        push(M_START, 0);
        start_pulse();
        wait_state(ST_SELECT, "g3_select");
        fill_board();
        rx(M_TURN, 0);
        wait_state(ST_MY, "g3_my");
        tx_ready = 1'b0;
        key(3);
        check("stall_state", game_state, ST_SEND_NUM);
        check("stall_tx", {tx_en, tx_type, tx_num}, {1'b1, M_SEL, 5'd3});
        tick();
        tick();
        check("stall_hold", {game_state, tx_en, tx_num}, {ST_SEND_NUM, 1'b1, 5'd3});
        link_rst = 1'b1;
        tick();
        link_rst = 1'b0;
        check("lrst_state", game_state, ST_IDLE);
        check("lrst_tx_en", tx_en, 1'b0);
        check("lrst_map", map, '0);
        check("lrst_circle", circle, '0);
        tx_ready = 1'b1;
        repeat (3) tick();
        check("exp_q_empty", exp_q.size(), 0);
        check("tx_en_outside_send", tx_bad, 0);
        check("err_total", err_seen, exp_err);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
